// File: rtl/mod_counter_pkg.sv
// mod_counter_pkg
//   Shared constants and parameter-legality helpers for the modulo counter
//   and its tick prescaler.
//   - DIR_UP / DIR_DOWN   : encodings of the dir input
//   - MODE_WRAP / MODE_SAT: encodings of the sat input
//   - *_legal functions   : elaboration-time parameter range checks
package mod_counter_pkg;

  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DOWN  = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  localparam int WIDTH_MIN    = 32'sd2;
  localparam int WIDTH_MAX    = 32'sd32;
  localparam int PRESCALE_MIN = 32'sd1;
  localparam int PRESCALE_MAX = 32'sd65536;

  function automatic bit width_legal(input int w);
    return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
  endfunction

  // MODULUS may reach 2**WIDTH, which needs 33 bits at WIDTH=32, so the
  // comparison is done in 64 bits.
  function automatic bit modulus_legal(input int w, input longint m);
    if (!width_legal(w)) begin
      return 1'b0;
    end else begin
      return (m >= 64'sd2) && (m <= (64'sd1 <<< w));
    end
  endfunction

  function automatic bit prescale_legal(input int p);
    return (p >= PRESCALE_MIN) && (p <= PRESCALE_MAX);
  endfunction

  // Bits needed to hold 0..p-1 (never less than one bit).
  function automatic int prescale_cnt_width(input int p);
    if (p <= 32'sd2) begin
      return 32'sd1;
    end else begin
      return $clog2(p);
    end
  endfunction

endpackage

// File: rtl/mod_counter_tick_prescaler.sv
// tick_prescaler
//   Divides enabled cycles by PRESCALE. tick is high (combinationally equal
//   to en) on the enabled cycle where the internal count sits at
//   PRESCALE-1; the count then returns to 0. The count only moves while
//   en=1, so disabled cycles do not consume prescaler progress.
//   Ports:
//   - clk   : rising-edge clock
//   - rst_n : asynchronous active-low reset, clears the count
//   - en    : advance enable
//   - clr   : synchronous clear of the count
//   - tick  : step strobe for the counter
module tick_prescaler
  import mod_counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  if (!prescale_legal(PRESCALE)) begin : g_bad_prescale
    $error("tick_prescaler: PRESCALE out of range 1..65536");
  end

  if (PRESCALE == 1) begin : g_passthru
    // Every enabled cycle is a tick; the clock/reset/clear have no state to act on.
    logic unused_s;
    assign unused_s = ^{clk, rst_n, clr};
    assign tick     = en;
  end else begin : g_divide
    localparam int CW = prescale_cnt_width(PRESCALE);
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] ONE  = {{(CW-1){1'b0}}, 1'b1};

    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_nxt_s;
    logic          at_last_s;

    // Next prescaler count: clear wins, then advance/rollover while enabled.
    always_comb begin
      at_last_s = (cnt_r == LAST);
      cnt_nxt_s = cnt_r;
      if (clr) begin
        cnt_nxt_s = ZERO;
      end else if (en) begin
        cnt_nxt_s = at_last_s ? ZERO : (cnt_r + ONE);
      end else begin
        cnt_nxt_s = cnt_r;
      end
    end

    // Prescaler count register.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_r <= ZERO;
      end else begin
        cnt_r <= cnt_nxt_s;
      end
    end

    assign tick = en & at_last_s;
  end

endmodule

// File: rtl/mod_counter.sv
// mod_counter
//   Up/down modulo-MODULUS counter with wrap or saturate boundary mode,
//   optional prescaled stepping, a one-cycle terminal-count pulse and a
//   sticky overflow flag. Per-edge priority: clr > load > step > hold.
//   Ports:
//   - clk, rst_n : clock and asynchronous active-low reset
//   - en         : count enable (also gates the prescaler)
//   - clr        : synchronous clear of out, prescaler, tc, ovf
//   - load       : synchronous load of load_val (clamped to MODULUS-1)
//   - load_val   : value to load
//   - dir        : 1 = up, 0 = down
//   - sat        : 1 = saturate at the bounds, 0 = wrap
//   - ovf_clr    : clears the sticky ovf flag (a same-edge boundary wins)
//   - out        : registered count
//   - tc         : registered pulse, high the cycle after a boundary step
//   - ovf        : sticky boundary flag
module mod_counter
  import mod_counter_pkg::*;
#(
  parameter int     WIDTH    = 8,
  parameter longint MODULUS  = 256,
  parameter int     PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dir,
  input  logic             sat,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             ovf
);

  if (!width_legal(WIDTH)) begin : g_bad_width
    $error("mod_counter: WIDTH out of range 2..32");
  end
  if (!modulus_legal(WIDTH, MODULUS)) begin : g_bad_modulus
    $error("mod_counter: MODULUS out of range 2..2**WIDTH");
  end

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 64'sd1);
  localparam logic [WIDTH-1:0] ZERO    = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE     = {{(WIDTH-1){1'b0}}, 1'b1};

  logic             tick_s;
  logic             step_s;
  logic             at_bound_s;
  logic             boundary_s;
  logic [WIDTH-1:0] step_val_s;
  logic [WIDTH-1:0] load_clamped_s;
  logic [WIDTH-1:0] out_nxt_s;
  logic             ovf_nxt_s;

  logic [WIDTH-1:0] out_r;
  logic             tc_r;
  logic             ovf_r;

  tick_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .clr   (clr),
    .tick  (tick_s)
  );

  // Step value and boundary detection. The bound is checked before any
  // arithmetic, so out_r+1 / out_r-1 never leave 0..MODULUS-1.
  always_comb begin
    step_s     = tick_s & ~clr & ~load;
    at_bound_s = 1'b0;
    step_val_s = out_r;
    if (dir == DIR_UP) begin
      at_bound_s = (out_r == MAX_VAL);
      if (at_bound_s) begin
        step_val_s = (sat == MODE_SAT) ? MAX_VAL : ZERO;
      end else begin
        step_val_s = out_r + ONE;
      end
    end else begin
      at_bound_s = (out_r == ZERO);
      if (at_bound_s) begin
        step_val_s = (sat == MODE_SAT) ? ZERO : MAX_VAL;
      end else begin
        step_val_s = out_r - ONE;
      end
    end
    // A saturating step at the bound still counts as a boundary event.
    boundary_s = step_s & at_bound_s;
  end

  // Next-state selection in clr > load > step > hold order.
  always_comb begin
    load_clamped_s = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    out_nxt_s      = out_r;
    ovf_nxt_s      = ovf_r;
    if (clr) begin
      out_nxt_s = ZERO;
      ovf_nxt_s = 1'b0;
    end else if (load) begin
      out_nxt_s = load_clamped_s;
      ovf_nxt_s = ovf_r & ~ovf_clr;
    end else begin
      out_nxt_s = step_s ? step_val_s : out_r;
      // Setting on a boundary takes precedence over a same-edge ovf_clr.
      if (boundary_s) begin
        ovf_nxt_s = 1'b1;
      end else if (ovf_clr) begin
        ovf_nxt_s = 1'b0;
      end else begin
        ovf_nxt_s = ovf_r;
      end
    end
  end

  // Count, terminal-count pulse and sticky overflow registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_r <= ZERO;
      tc_r  <= 1'b0;
      ovf_r <= 1'b0;
    end else begin
      out_r <= out_nxt_s;
      tc_r  <= boundary_s;
      ovf_r <= ovf_nxt_s;
    end
  end

  assign out = out_r;
  assign tc  = tc_r;
  assign ovf = ovf_r;

endmodule
